pc_test_monitor: RTL and testbench
==================================

PC_TEST_MONITOR -- requirements
Module: pc_test_monitor

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, PC and address width.
REQ-002 The block SHALL have parameter NUM_PASS, default 1, number of pass addresses (1..8).
REQ-003 The block SHALL have parameter NUM_FAIL, default 1, number of fail addresses (1..8).
REQ-004 The block SHALL have parameter CNT_W, default 32, width of the cycle and retire counters.
REQ-005 The block SHALL have parameter STALL_LIMIT, default 16, consecutive identical-PC retires that flag a hang.
REQ-006 The block SHALL use one clock; reset is asynchronous and active-low (ports clk, rst_n).
REQ-007 The block SHALL have port clk  input  1  clock.
REQ-008 The block SHALL have port rst_n  input  1  async active-low reset.
REQ-009 The block SHALL have port start  input  1  begin or restart a run.
REQ-010 The block SHALL have port clear  input  1  return to IDLE.
REQ-011 The block SHALL have port pc_valid  input  1  pc holds a retiring instruction this cycle.
REQ-012 The block SHALL have port pc  input  XLEN  program counter.
REQ-013 The block SHALL have port pass_addr  input  NUM_PASS*XLEN  packed pass addresses, entry 0 in LSBs.
REQ-014 The block SHALL have port fail_addr  input  NUM_FAIL*XLEN  packed fail addresses.
REQ-015 The block SHALL have port timeout_cycles  input  CNT_W  run limit; 0 disables the timeout.
REQ-016 The block SHALL have port done  output  1  run ended.
REQ-017 The block SHALL have port status  output  3  mon_status_t code.
REQ-018 The block SHALL have port cycle_count  output  CNT_W  cycles spent in RUN.
REQ-019 The block SHALL have port retired_count  output  CNT_W  pc_valid beats seen in RUN.
REQ-020 The block SHALL have port end_pc  output  XLEN  PC captured at termination.

Function
REQ-021 The block SHALL implement states IDLE, RUN, PASS, FAIL, TIMEOUT, HANG; status reports the current state.
REQ-022 In IDLE, start SHALL move to RUN next cycle, zeroing both counters, end_pc and the stall counter.
REQ-023 In RUN, cycle_count SHALL increment every cycle and retired_count every pc_valid cycle; both saturate at all-ones.
REQ-024 In RUN with pc_valid, a pc equal to any fail_addr entry SHALL move to FAIL; fail has priority over a simultaneous pass match.
REQ-025 In RUN with pc_valid, a pc equal to any pass_addr entry (and no fail match) SHALL move to PASS.
REQ-026 Stall counter: pc_valid with pc equal to the previous retired pc SHALL increment it, a different pc SHALL reset it to 0; reaching STALL_LIMIT with no pass/fail match SHALL move to HANG.
REQ-027 With timeout_cycles nonzero and cycle_count equal to timeout_cycles-1 in RUN, with no other event, the block SHALL move to TIMEOUT.
REQ-028 Priority in one cycle SHALL be FAIL > PASS > HANG > TIMEOUT.
REQ-029 On entering any terminal state, end_pc SHALL load the current pc; done SHALL be high exactly while in a terminal state, one cycle after the triggering beat.
REQ-030 Terminal states SHALL hold counters and end_pc frozen; start SHALL restart as in REQ-022, and clear SHALL go to IDLE.
REQ-031 clear SHALL have priority over start in every state; clear in RUN aborts to IDLE, preserving the counters.
REQ-032 Matching SHALL sample pass_addr/fail_addr combinationally each cycle; changes mid-run take effect immediately.

Reset
REQ-033 rst_n low SHALL force state IDLE, done 0, status IDLE, and counters, end_pc, stall counter and previous pc to 0, asynchronously; reset mid-run discards the run.

Structure
REQ-034 The shared package SHALL hold mon_status_t (IDLE=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4, HANG=5) and a STALL_W width function.
REQ-035 The block SHALL instantiate sub-module pc_addr_match (parameters XLEN, N) twice, producing one hit bit from a packed address list.

Verification
REQ-036 The bench SHALL cover: pass_addr=0x100, retire 0x0,0x4,...,0x100 -> done the cycle after 0x100, status PASS, end_pc 0x100, retired_count 65.
REQ-037 The bench SHALL cover: NUM_FAIL=2, fail_addr={0x200,0x80}, retire 0x80 -> status FAIL, end_pc 0x80.
REQ-038 The bench SHALL cover: pass and fail both 0x40, retire 0x40 -> status FAIL.
REQ-039 The bench SHALL cover: timeout_cycles=1000, pc_valid never high -> TIMEOUT with cycle_count 999; timeout_cycles=0 -> still RUN after 5000 cycles.
REQ-040 The bench SHALL cover: STALL_LIMIT=16, retire 0x300 repeatedly -> HANG after the 17th beat; the same with pass_addr=0x300 -> PASS on the first beat.
REQ-041 The bench SHALL cover: rst_n low mid-run -> IDLE, all outputs 0 immediately; afterwards start -> RUN with zeroed counters.

Source files
------------

// File: rtl/pc_test_monitor_pkg.sv
// Shared types and helpers for the PC test monitor.
//   mon_status_t : status/state code reported on the status port
//   STALL_W      : width of a counter that must hold 0..limit
package pc_test_monitor_pkg;

  localparam int unsigned STATUS_W = 3;

  typedef enum logic [STATUS_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4,
    ST_HANG    = 3'd5
  } mon_status_t;

  // Bits needed to count from 0 up to and including limit.
  function automatic int unsigned STALL_W(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/pc_test_monitor_if.sv
// Monitor bus: run control, retire stream, address lists and run results.
//   master : the agent driving the monitor (drives controls, reads results)
//   slave  : the monitor itself
interface pc_test_monitor_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_PASS = 1,
  parameter int unsigned NUM_FAIL = 1,
  parameter int unsigned CNT_W    = 32
) ();
  import pc_test_monitor_pkg::*;

  logic                     start;
  logic                     clear;
  logic                     pc_valid;
  logic [XLEN-1:0]          pc;
  logic [NUM_PASS*XLEN-1:0] pass_addr;
  logic [NUM_FAIL*XLEN-1:0] fail_addr;
  logic [CNT_W-1:0]         timeout_cycles;
  logic                     done;
  mon_status_t              status;
  logic [CNT_W-1:0]         cycle_count;
  logic [CNT_W-1:0]         retired_count;
  logic [XLEN-1:0]          end_pc;

  modport master (
    output start, clear, pc_valid, pc, pass_addr, fail_addr, timeout_cycles,
    input  done, status, cycle_count, retired_count, end_pc
  );

  modport slave (
    input  start, clear, pc_valid, pc, pass_addr, fail_addr, timeout_cycles,
    output done, status, cycle_count, retired_count, end_pc
  );

endinterface

// File: rtl/pc_test_monitor_addr_match.sv
// Compares one PC against a packed list of N addresses (entry 0 in LSBs).
//   i_pc        : PC to compare
//   i_addr_list : N*XLEN packed address list
//   o_hit_c     : combinational, high if any entry equals i_pc
module pc_addr_match #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned N    = 1
) (
  input  logic [XLEN-1:0]   i_pc,
  input  logic [N*XLEN-1:0] i_addr_list,
  output logic              o_hit_c
);

  // OR-reduce of per-entry equality.
  always_comb begin
    o_hit_c = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      if (i_addr_list[k*XLEN +: XLEN] == i_pc) o_hit_c = 1'b1;
    end
  end

endmodule

// File: rtl/pc_test_monitor.sv
// Watches a retiring-PC stream during a test run and ends the run on a
// fail/pass address hit, a stuck PC (hang) or a cycle timeout.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of pc_test_monitor_if
//                in : start, clear, pc_valid, pc, pass_addr, fail_addr,
//                     timeout_cycles
//                out: done, status, cycle_count, retired_count, end_pc
module pc_test_monitor
  import pc_test_monitor_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NUM_PASS    = 1,
  parameter int unsigned NUM_FAIL    = 1,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned STALL_LIMIT = 16
) (
  input logic               clk,
  input logic               rst_n,
  pc_test_monitor_if.slave  bus
);

  localparam int unsigned     SW        = STALL_W(STALL_LIMIT);
  localparam logic [SW-1:0]   STALL_TOP = SW'(STALL_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  mon_status_t       r_state;
  logic              r_done;
  logic [CNT_W-1:0]  r_cycle_cnt;
  logic [CNT_W-1:0]  r_retired_cnt;
  logic [XLEN-1:0]   r_end_pc;
  logic [SW-1:0]     r_stall_cnt;
  logic [XLEN-1:0]   r_prev_pc;
  logic              r_prev_vld;

  logic              w_pass_raw;
  logic              w_fail_raw;
  logic              w_pass_hit;
  logic              w_fail_hit;
  logic [SW-1:0]     w_stall_nxt;
  logic              w_hang;
  logic              w_timeout;
  logic              w_end_run;
  mon_status_t       w_term_state;

  pc_addr_match #(.XLEN(XLEN), .N(NUM_PASS)) u_pass_match (
    .i_pc        (bus.pc),
    .i_addr_list (bus.pass_addr),
    .o_hit_c     (w_pass_raw)
  );

  pc_addr_match #(.XLEN(XLEN), .N(NUM_FAIL)) u_fail_match (
    .i_pc        (bus.pc),
    .i_addr_list (bus.fail_addr),
    .o_hit_c     (w_fail_raw)
  );

  assign w_fail_hit = bus.pc_valid & w_fail_raw;
  assign w_pass_hit = bus.pc_valid & w_pass_raw;

  // Repeat count of the retiring PC; the first beat after start has no
  // predecessor, so it never counts as a repeat.
  always_comb begin
    w_stall_nxt = '0;
    if (r_prev_vld && (bus.pc == r_prev_pc)) begin
      w_stall_nxt = (r_stall_cnt == STALL_TOP) ? r_stall_cnt : r_stall_cnt + SW'(1);
    end
  end

  assign w_hang    = bus.pc_valid && (w_stall_nxt == STALL_TOP);
  assign w_timeout = (bus.timeout_cycles != '0) &&
                     (r_cycle_cnt == bus.timeout_cycles - CNT_W'(1));
  assign w_end_run = w_fail_hit | w_pass_hit | w_hang | w_timeout;

  // Terminal state selection: FAIL > PASS > HANG > TIMEOUT.
  always_comb begin
    w_term_state = ST_TIMEOUT;
    if (w_fail_hit)      w_term_state = ST_FAIL;
    else if (w_pass_hit) w_term_state = ST_PASS;
    else if (w_hang)     w_term_state = ST_HANG;
  end

  // Run-control FSM with counters; the cycle that ends a run is not added
  // to cycle_count, but a retiring beat on that cycle is counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_done        <= 1'b0;
      r_cycle_cnt   <= '0;
      r_retired_cnt <= '0;
      r_end_pc      <= '0;
      r_stall_cnt   <= '0;
      r_prev_pc     <= '0;
      r_prev_vld    <= 1'b0;
    end else if (bus.clear) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else if (bus.start && (r_state != ST_RUN)) begin
      r_state       <= ST_RUN;
      r_done        <= 1'b0;
      r_cycle_cnt   <= '0;
      r_retired_cnt <= '0;
      r_end_pc      <= '0;
      r_stall_cnt   <= '0;
      r_prev_vld    <= 1'b0;
    end else if (r_state == ST_RUN) begin
      if (bus.pc_valid) begin
        if (r_retired_cnt != CNT_MAX) r_retired_cnt <= r_retired_cnt + CNT_W'(1);
        r_stall_cnt <= w_stall_nxt;
        r_prev_pc   <= bus.pc;
        r_prev_vld  <= 1'b1;
      end
      if (w_end_run) begin
        r_state  <= w_term_state;
        r_done   <= 1'b1;
        r_end_pc <= bus.pc;
      end else if (r_cycle_cnt != CNT_MAX) begin
        r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.done          = r_done;
  assign bus.status        = r_state;
  assign bus.cycle_count   = r_cycle_cnt;
  assign bus.retired_count = r_retired_cnt;
  assign bus.end_pc        = r_end_pc;

endmodule

// File: tb/tb_pc_test_monitor.sv
// Testbench for pc_test_monitor: vector table, directed corner sequences and
// a randomized run against a behavioural model.
module tb_pc_test_monitor;
  import pc_test_monitor_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NP   = 2;
  localparam int unsigned NF   = 2;
  localparam int unsigned CW   = 32;
  localparam int unsigned SL   = 16;
  localparam longint      CMAX = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_test_monitor_if #(.XLEN(XLEN), .NUM_PASS(NP), .NUM_FAIL(NF), .CNT_W(CW)) mif ();

  pc_test_monitor #(.XLEN(XLEN), .NUM_PASS(NP), .NUM_FAIL(NF), .CNT_W(CW),
                    .STALL_LIMIT(SL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic st, input logic cl, input logic v, input logic [31:0] p);
    mif.start    = st;
    mif.clear    = cl;
    mif.pc_valid = v;
    mif.pc       = p;
    tick();
  endtask

  task automatic check_out(input string name, input int st, input logic dn,
                           input longint cyc, input longint ret, input logic [31:0] ep);
    check({name, ".status"}, 128'(mif.status), 128'(st));
    check({name, ".done"},   128'(mif.done),   128'(dn));
    check({name, ".cycles"}, 128'(mif.cycle_count),   128'(cyc[31:0]));
    check({name, ".retired"},128'(mif.retired_count), 128'(ret[31:0]));
    check({name, ".end_pc"}, 128'(mif.end_pc), 128'(ep));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // Vector table record
  typedef struct {
    logic        start;
    logic        clear;
    logic        valid;
    logic [31:0] pc;
    int          exp_status;
    logic        exp_done;
    longint      exp_cyc;
    longint      exp_ret;
    logic [31:0] exp_end;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic c, input logic v, input logic [31:0] p,
                              input int es, input logic ed, input longint ec,
                              input longint er, input logic [31:0] ee);
    vec_t t;
    t.start = s; t.clear = c; t.valid = v; t.pc = p;
    t.exp_status = es; t.exp_done = ed; t.exp_cyc = ec; t.exp_ret = er; t.exp_end = ee;
    return t;
  endfunction

  // Behavioural reference model state
  int          m_st;
  longint      m_cyc, m_ret;
  logic [31:0] m_end, m_prev;
  bit          m_hasprev;
  int          m_rep;

  function automatic bit in_list(input logic [31:0] p, input logic [63:0] lst);
    return (p == lst[31:0]) || (p == lst[63:32]);
  endfunction

  task automatic model_reset();
    m_st = 0; m_cyc = 0; m_ret = 0; m_end = '0; m_prev = '0; m_hasprev = 0; m_rep = 0;
  endtask

  // One clock of the monitor as the rules describe it (status codes as ints).
  task automatic model_step(input bit st, input bit cl, input bit v, input logic [31:0] p,
                            input logic [63:0] pl, input logic [63:0] fl, input longint tmo);
    int nxt;
    if (cl) begin
      m_st = 0;
    end else if (st && m_st != 1) begin
      m_st = 1; m_cyc = 0; m_ret = 0; m_end = '0; m_rep = 0; m_hasprev = 0;
    end else if (m_st == 1) begin
      nxt = 1;
      if (v) begin
        if (m_ret < CMAX) m_ret++;
        if (m_hasprev && p == m_prev) m_rep = (m_rep < int'(SL)) ? m_rep + 1 : m_rep;
        else m_rep = 0;
        m_prev = p;
        m_hasprev = 1;
      end
      if (v && in_list(p, fl))             nxt = 3;
      else if (v && in_list(p, pl))        nxt = 2;
      else if (v && m_rep >= int'(SL))     nxt = 5;
      else if (tmo != 0 && m_cyc == tmo-1) nxt = 4;
      if (nxt != 1) begin
        m_st = nxt;
        m_end = p;
      end else if (m_cyc < CMAX) begin
        m_cyc++;
      end
    end
  endtask

  initial begin
    vec_t        vt[$];
    int          n;
    logic [31:0] rpc;
    bit          rst, rcl, rv;
    logic [127:0] exp_v, act_v;

    rst_n = 1'b0;
    mif.start = 0; mif.clear = 0; mif.pc_valid = 0; mif.pc = '0;
    mif.pass_addr = {32'h500, 32'h40};
    mif.fail_addr = {32'h600, 32'h40};
    mif.timeout_cycles = '0;
    #1;
    check_out("reset", 0, 0, 0, 0, 32'h0);
    do_reset();

    // Table-driven control sequence (pass and fail both contain 0x40)
    vt.push_back(mk(1,0,0,32'h0,   1,0,0,0,32'h0));
    vt.push_back(mk(0,0,1,32'h10,  1,0,1,1,32'h0));
    vt.push_back(mk(0,0,1,32'h40,  3,1,1,2,32'h40));
    vt.push_back(mk(0,0,0,32'h0,   3,1,1,2,32'h40));
    vt.push_back(mk(0,1,0,32'h0,   0,0,1,2,32'h40));
    vt.push_back(mk(1,0,0,32'h0,   1,0,0,0,32'h0));
    vt.push_back(mk(0,0,1,32'h44,  1,0,1,1,32'h0));
    vt.push_back(mk(0,1,0,32'h0,   0,0,1,1,32'h0));
    vt.push_back(mk(1,1,0,32'h0,   0,0,1,1,32'h0));
    vt.push_back(mk(1,0,0,32'h0,   1,0,0,0,32'h0));
    vt.push_back(mk(0,0,1,32'h500, 2,1,0,1,32'h500));
    vt.push_back(mk(1,0,0,32'h0,   1,0,0,0,32'h0));
    vt.push_back(mk(0,0,0,32'h40,  1,0,1,0,32'h0));
    vt.push_back(mk(0,1,0,32'h0,   0,0,1,0,32'h0));
    foreach (vt[i]) begin
      step(vt[i].start, vt[i].clear, vt[i].valid, vt[i].pc);
      check_out($sformatf("vec%0d", i), vt[i].exp_status, vt[i].exp_done,
                vt[i].exp_cyc, vt[i].exp_ret, vt[i].exp_end);
    end

    // Pass at 0x100 after retiring 0x0..0x100
    mif.pass_addr = {32'h500, 32'h100};
    mif.fail_addr = {32'h600, 32'h700};
    step(1,0,0,0);
    for (int a = 0; a <= 32'h100; a += 4) begin
      step(0,0,1,32'(a));
      if (a == 32'hFC) check("pass.early_done", 128'(mif.done), 128'(0));
    end
    check_out("pass", 2, 1, 64, 65, 32'h100);

    // Two-entry fail list, match on entry 0
    mif.fail_addr = {32'h200, 32'h80};
    step(1,0,0,0);
    step(0,0,1,32'h7C);
    step(0,0,1,32'h80);
    check_out("fail2", 3, 1, 1, 2, 32'h80);

    // Timeout of 1000 with no retires
    mif.timeout_cycles = 32'd1000;
    step(1,0,0,0);
    n = 0;
    while (!mif.done && n < 1100) begin
      step(0,0,0,32'h1234);
      n++;
    end
    check("tmo.latency", 128'(n), 128'(1000));
    check_out("tmo", 4, 1, 999, 0, 32'h1234);

    // Timeout disabled
    mif.timeout_cycles = '0;
    step(1,0,0,0);
    repeat (5000) step(0,0,0,0);
    check_out("notmo", 1, 0, 5000, 0, 32'h0);

    // Hang after 17 identical beats
    mif.pass_addr = {32'h500, 32'h504};
    mif.fail_addr = {32'h600, 32'h604};
    step(0,1,0,0);
    step(1,0,0,0);
    repeat (16) step(0,0,1,32'h300);
    check_out("hang.16", 1, 0, 16, 16, 32'h0);
    step(0,0,1,32'h300);
    check_out("hang.17", 5, 1, 16, 17, 32'h300);

    // Same stream but 0x300 is a pass address
    mif.pass_addr = {32'h500, 32'h300};
    step(1,0,0,0);
    step(0,0,1,32'h300);
    check_out("hangpass", 2, 1, 0, 1, 32'h300);

    // Asynchronous reset mid-run
    step(1,0,0,0);
    step(0,0,1,32'h10);
    step(0,0,1,32'h14);
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    step(1,0,0,0);
    check_out("after_rst", 1, 0, 0, 0, 32'h0);

    // Randomized run against the model
    do_reset();
    model_reset();
    rpc = 32'h300;
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 0) begin
        mif.pass_addr = {32'h300 + 32'(4*$urandom_range(0,15)), 32'h300 + 32'(4*$urandom_range(0,15))};
        mif.fail_addr = {32'h300 + 32'(4*$urandom_range(0,15)), 32'h300 + 32'(4*$urandom_range(0,15))};
        mif.timeout_cycles = ($urandom_range(0,2) == 0) ? 32'd0 : 32'($urandom_range(40,400));
      end
      rst = (m_st != 1) ? ($urandom_range(0,3) == 0) : ($urandom_range(0,50) == 0);
      rcl = ($urandom_range(0,150) == 0);
      rv  = ($urandom_range(0,3) != 0);
      if ($urandom_range(0,9) == 0) rpc = 32'h300 + 32'(4*$urandom_range(0,7));
      model_step(rst, rcl, rv, rpc, mif.pass_addr, mif.fail_addr, longint'(mif.timeout_cycles));
      step(rst, rcl, rv, rpc);
      exp_v = {25'd0, (m_st >= 2), 3'(m_st), m_cyc[31:0], m_ret[31:0], m_end};
      act_v = {25'd0, mif.done, mif.status, mif.cycle_count, mif.retired_count, mif.end_pc};
      check($sformatf("rand%0d", i), act_v, exp_v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
